// File: rtl/pc_sequencer.sv
// pc_sequencer: holds the architectural PC and sequences the next PC for
// SEQ, BRANCH (via the external branch comparison unit), JAL and JALR.
// Optional feature macro: MISALIGN_TRAP_EN. When defined, a misaligned target
// pulses `misaligned` and leaves the PC alone. When undefined, the low two
// target bits are forced to zero and the target commits normally.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        advance,
    input  logic [1:0]  kind,
    input  logic [31:0] imm,
    input  logic [31:0] rs1,
    output logic        br_start,
    input  logic        br_done,
    input  logic        br_jump,
    output logic        ready,
    output logic [31:0] pc,
    output logic [31:0] link,
    output logic        pc_valid,
    output logic        misaligned,
    output logic [31:0] instret
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_BR = 2'd1,
        S_COMMIT  = 2'd2
    } state_t;

    localparam logic [1:0] KIND_SEQ    = 2'b00;
    localparam logic [1:0] KIND_BRANCH = 2'b01;
    localparam logic [1:0] KIND_JAL    = 2'b10;
    localparam logic [1:0] KIND_JALR   = 2'b11;

    state_t      r_state;
    state_t      w_stateNext;
    logic [31:0] r_pc;
    logic [31:0] r_link;
    logic [31:0] r_instret;
    logic [31:0] r_imm;
    logic [31:0] r_target;
    logic        r_brStart;
    logic        r_pcValid;
    logic        r_ready;
    logic [31:0] w_target;
    logic [31:0] w_targetFinal;
    logic        w_loadTarget;
    logic        w_accept;

    assign w_accept = (r_state == S_IDLE) && advance;

`ifdef MISALIGN_TRAP_EN
    logic r_misaligned;
    assign w_targetFinal = w_target;
`else
    assign w_targetFinal = w_target & 32'hFFFF_FFFC;
`endif

    // Next-state selection and target computation; r_brStart doubles as the first-WAIT_BR-cycle flag
    always_comb begin
        w_stateNext  = r_state;
        w_target     = r_target;
        w_loadTarget = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (advance) begin
                    w_loadTarget = 1'b1;
                    case (kind)
                        KIND_SEQ:    w_target = r_pc + 32'd4;
                        KIND_JAL:    w_target = r_pc + imm;
                        KIND_JALR:   w_target = (rs1 + imm) & 32'hFFFF_FFFE;
                        default:     w_target = r_pc + 32'd4;
                    endcase
                    if (kind == KIND_BRANCH) begin
                        w_stateNext  = S_WAIT_BR;
                        w_loadTarget = 1'b0;
                    end else begin
                        w_stateNext = S_COMMIT;
                    end
                end
            end
            S_WAIT_BR: begin
                if (!r_brStart && br_done) begin
                    w_loadTarget = 1'b1;
                    w_target     = br_jump ? (r_pc + r_imm) : r_link;
                    w_stateNext  = S_COMMIT;
                end
            end
            S_COMMIT: begin
                w_stateNext = S_IDLE;
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Datapath and registered output pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc      <= RESET_VECTOR;
            r_link    <= 32'd0;
            r_instret <= 32'd0;
            r_imm     <= 32'd0;
            r_target  <= 32'd0;
            r_brStart <= 1'b0;
            r_pcValid <= 1'b0;
            r_ready   <= 1'b1;
        end else begin
            r_brStart <= w_accept && (kind == KIND_BRANCH);
            r_ready   <= (w_stateNext == S_IDLE);
            r_pcValid <= 1'b0;
            if (w_accept) begin
                r_link <= r_pc + 32'd4;
                r_imm  <= imm;
            end
            if (w_loadTarget) begin
                r_target <= w_targetFinal;
            end
            if (r_state == S_COMMIT) begin
`ifdef MISALIGN_TRAP_EN
                if (r_target[1:0] == 2'b00) begin
                    r_pc      <= r_target;
                    r_pcValid <= 1'b1;
                    r_instret <= r_instret + 32'd1;
                end
`else
                r_pc      <= r_target;
                r_pcValid <= 1'b1;
                r_instret <= r_instret + 32'd1;
`endif
            end
        end
    end

`ifdef MISALIGN_TRAP_EN
    // Trap pulse raised instead of pc_valid when the committed target is misaligned
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_misaligned <= 1'b0;
        end else begin
            r_misaligned <= (r_state == S_COMMIT) && (r_target[1:0] != 2'b00);
        end
    end
    assign misaligned = r_misaligned;
`else
    assign misaligned = 1'b0;
`endif

    assign br_start = r_brStart;
    assign ready    = r_ready;
    assign pc       = r_pc;
    assign link     = r_link;
    assign pc_valid = r_pcValid;
    assign instret  = r_instret;

endmodule
